// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SKID,
    DRAIN
  } fetch_state_t;

  localparam int INST_BYTES = 4;

endpackage

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch stage: owns the PC, handshakes with instruction memory and feeds IF/ID
// through a valid/stall output buffer backed by a one-entry skid register.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReq,
  output logic [63:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  input  logic        Stall,
  input  logic        BrTaken,
  input  logic [63:0] BrTarget,
  output logic [63:0] IFPC,
  output logic [31:0] IFInst,
  output logic        IFValid
);

  fetch_state_t state_reg, state_next;
  logic [63:0]  pc_reg, pc_next;
  logic [63:0]  drain_addr_reg, drain_addr_next;
  logic         valid_reg, valid_next;
  logic [63:0]  out_pc_reg, out_pc_next;
  logic [31:0]  out_inst_reg, out_inst_next;
  logic [63:0]  skid_pc_reg, skid_pc_next;
  logic [31:0]  skid_inst_reg, skid_inst_next;
  logic         out_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      drain_addr_reg <= 64'h0;
      valid_reg      <= 1'b0;
      out_pc_reg     <= 64'h0;
      out_inst_reg   <= 32'h0;
      skid_pc_reg    <= 64'h0;
      skid_inst_reg  <= 32'h0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      drain_addr_reg <= drain_addr_next;
      valid_reg      <= valid_next;
      out_pc_reg     <= out_pc_next;
      out_inst_reg   <= out_inst_next;
      skid_pc_reg    <= skid_pc_next;
      skid_inst_reg  <= skid_inst_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    drain_addr_next = drain_addr_reg;
    valid_next      = valid_reg;
    out_pc_next     = out_pc_reg;
    out_inst_next   = out_inst_reg;
    skid_pc_next    = skid_pc_reg;
    skid_inst_next  = skid_inst_reg;
    out_free        = ~valid_reg | ~Stall;

    // A consumed instruction leaves the buffer unless something refills it below.
    if (valid_reg && !Stall) begin
      valid_next = 1'b0;
    end

    if (BrTaken) begin
      pc_next    = BrTarget & ~64'h3;
      valid_next = 1'b0;
      case (state_reg)
        REQ: begin
          if (!ImemAck) begin
            state_next      = DRAIN;
            drain_addr_next = pc_reg;
          end else begin
            state_next = REQ;
          end
        end
        DRAIN:   state_next = ImemAck ? REQ : DRAIN;
        default: state_next = REQ;
      endcase
    end else begin
      case (state_reg)
        IDLE: state_next = REQ;
        REQ: begin
          if (ImemAck) begin
            pc_next = pc_reg + 64'(INST_BYTES);
            if (out_free) begin
              out_pc_next   = pc_reg;
              out_inst_next = ImemData;
              valid_next    = 1'b1;
            end else begin
              skid_pc_next   = pc_reg;
              skid_inst_next = ImemData;
              state_next     = SKID;
            end
          end
        end
        SKID: begin
          if (!Stall) begin
            out_pc_next   = skid_pc_reg;
            out_inst_next = skid_inst_reg;
            valid_next    = 1'b1;
            state_next    = REQ;
          end
        end
        DRAIN: begin
          if (ImemAck) begin
            state_next = REQ;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign ImemReq  = (state_reg == REQ) || (state_reg == DRAIN);
  assign ImemAddr = (state_reg == DRAIN) ? drain_addr_reg : pc_reg;
  assign IFPC     = out_pc_reg;
  assign IFInst   = out_inst_reg;
  assign IFValid  = valid_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized Stall/Ack/BrTaken traffic.
module tb_instruction_fetch_unit;

  localparam logic [63:0] RST_PC  = 64'h100;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ImemReq;
  logic [63:0] ImemAddr;
  logic        ImemAck = 1'b0;
  logic [31:0] ImemData = 32'h0;
  logic        Stall = 1'b0;
  logic        BrTaken = 1'b0;
  logic [63:0] BrTarget = 64'h0;
  logic [63:0] IFPC;
  logic [31:0] IFInst;
  logic        IFValid;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_ack = 1'b1;
  logic [31:0] w_data;
  logic        w_stall = 1'b0;
  logic        w_br = 1'b0;
  logic [63:0] w_tgt = 64'h0;
  logic [63:0] w_pc;
  logic [31:0] w_inst;
  logic        w_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RST_PC)) u_dut (
    .clk(clk), .reset(reset), .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck),
    .ImemData(ImemData), .Stall(Stall), .BrTaken(BrTaken), .BrTarget(BrTarget),
    .IFPC(IFPC), .IFInst(IFInst), .IFValid(IFValid)
  );

  instruction_fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .reset(reset), .ImemReq(w_req), .ImemAddr(w_addr), .ImemAck(w_ack),
    .ImemData(w_data), .Stall(w_stall), .BrTaken(w_br), .BrTarget(w_tgt),
    .IFPC(w_pc), .IFInst(w_inst), .IFValid(w_valid)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ a[63:32] ^ 32'hA5C3_1E77;
  endfunction

  assign w_data = mem_word(w_addr);

  // Reference model: fetched-but-unconsumed instructions form a queue of at most two
  // (presented + skid); a redirect with a request in flight leaves one ack to discard.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      m_q[$];
  logic [63:0] m_pc = RST_PC;
  bit          m_started = 1'b0;
  bit          m_drain = 1'b0;
  logic [63:0] m_drain_addr = 64'h0;

  function automatic bit m_req();
    return m_started && (m_drain || m_q.size() < 2);
  endfunction

  function automatic logic [63:0] m_addr();
    return m_drain ? m_drain_addr : m_pc;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_q.delete();
        m_pc         = RST_PC;
        m_started    = 1'b0;
        m_drain      = 1'b0;
        m_drain_addr = 64'h0;
      end else begin
        bit req;
        req = m_req();
        if (!m_started) begin
          m_started = 1'b1;
          if (BrTaken) m_pc = BrTarget & ~64'h3;
        end else if (BrTaken) begin
          m_q.delete();
          if (req && !ImemAck) begin
            if (!m_drain) m_drain_addr = m_pc;
            m_drain = 1'b1;
          end else begin
            m_drain = 1'b0;
          end
          m_pc = BrTarget & ~64'h3;
        end else begin
          if (m_q.size() > 0 && !Stall) void'(m_q.pop_front());
          if (req && ImemAck) begin
            if (m_drain) begin
              m_drain = 1'b0;
            end else begin
              m_q.push_back('{pc: m_pc, inst: ImemData});
              m_pc = m_pc + 64'd4;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_ImemReq", 64'(ImemReq), 64'h0);
        chk("rst_IFValid", 64'(IFValid), 64'h0);
        chk("rst_IFPC", IFPC, 64'h0);
        chk("rst_IFInst", 64'(IFInst), 64'h0);
      end else begin
        chk("ImemReq", 64'(ImemReq), 64'(m_req()));
        if (m_req()) chk("ImemAddr", ImemAddr, m_addr());
        chk("IFValid", 64'(IFValid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
          chk("IFPC", IFPC, m_q[0].pc);
          chk("IFInst", 64'(IFInst), 64'(m_q[0].inst));
        end
      end
    end
  end

  // Drive one cycle's inputs right after an edge; memory only acks an open request.
  task automatic cyc(input bit ack, input bit stl, input bit br, input logic [63:0] tgt);
    ImemAck  = ack && m_req();
    ImemData = ImemAck ? mem_word(m_addr()) : $urandom;
    Stall    = stl;
    BrTaken  = br;
    BrTarget = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic sync_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b1;
    #1;
    chk("async_IFValid", 64'(IFValid), 64'h0);
    chk("async_ImemReq", 64'(ImemReq), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    ImemAck = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Streaming from RESET_PC with ack tied high; wrap instance runs alongside.
    chk("idle_ImemReq", 64'(ImemReq), 64'h0);
    cyc(1, 0, 0, 0);
    chk("first_addr", ImemAddr, 64'h100);
    chk("wrap_addr0", w_addr, WRAP_PC);
    cyc(1, 0, 0, 0);
    chk("stream_pc0", IFPC, 64'h100);
    chk("wrap_addr1", w_addr, 64'h0);
    chk("wrap_pc0", w_pc, WRAP_PC);
    chk("wrap_inst0", 64'(w_inst), 64'(mem_word(WRAP_PC)));
    cyc(1, 0, 0, 0);
    chk("stream_pc1", IFPC, 64'h104);
    cyc(1, 0, 0, 0);
    chk("stream_pc2", IFPC, 64'h108);
    chk("stream_valid", 64'(IFValid), 64'h1);

    // Stall with skid.
    sync_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("pre_stall_pc", IFPC, 64'h104);
    cyc(1, 1, 0, 0);
    chk("skid_req_low", 64'(ImemReq), 64'h0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("stall_hold_pc", IFPC, 64'h104);
    cyc(0, 0, 0, 0);
    chk("skid_out_pc", IFPC, 64'h108);
    chk("skid_out_inst", 64'(IFInst), 64'(mem_word(64'h108)));
    chk("after_skid_addr", ImemAddr, 64'h10C);

    // Redirect with ack in the same cycle, then redirect mid-request.
    cyc(1, 0, 1, 64'h200);
    chk("br_ack_valid", 64'(IFValid), 64'h0);
    chk("br_ack_addr", ImemAddr, 64'h200);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 64'h403);
    chk("drain_addr", ImemAddr, 64'h200);
    cyc(1, 0, 0, 0);
    chk("drain_valid", 64'(IFValid), 64'h0);
    chk("target_addr", ImemAddr, 64'h400);
    cyc(1, 0, 0, 0);
    chk("target_pc", IFPC, 64'h400);

    // Asynchronous reset while in SKID, then restart.
    cyc(1, 1, 0, 0);
    chk("in_skid_req", 64'(ImemReq), 64'h0);
    async_reset_pulse();
    cyc(1, 0, 0, 0);
    chk("restart_addr", ImemAddr, 64'h100);
    cyc(1, 0, 0, 0);
    chk("restart_pc", IFPC, 64'h100);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [63:0] tgt;
      if ($urandom_range(0, 3) == 0)
        tgt = {32'hFFFF_FFFF, 32'hFFFF_FFE0 | 32'($urandom_range(0, 31))};
      else
        tgt = {32'h0, $urandom};
      if ($urandom_range(0, 399) == 0) begin
        async_reset_pulse();
      end else begin
        cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
            $urandom_range(0, 99) < 7, tgt);
      end
    end
    cyc(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
